// File: rtl/if_stage.sv
// Instruction-fetch stage: holds one fetch bundle, waits for its instruction
// beat when needed, and swallows beats that belong to requests killed by a flush.
module if_stage #(
  parameter int FS_TO_DS_BUS_WD  = 103,
  parameter int PFS_TO_FS_BUS_WD = 104
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pfs_to_fs_valid,
  input  logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus,
  input  logic                        pfs_inst_waiting,
  output logic                        fs_allowin,
  output logic                        fs_valid,
  output logic                        fs_inst_unable,
  input  logic                        inst_sram_data_ok,
  input  logic [31:0]                 inst_sram_rdata,
  input  logic                        ds_allowin,
  output logic                        fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0]  fs_to_ds_bus,
  input  logic                        do_flush
);
  logic        fs_valid_q, fs_valid_d;
  logic [31:0] pc_q, pc_d;
  logic        ex_q, ex_d;
  logic [4:0]  excode_q, excode_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        tlb_refill_q, tlb_refill_d;
  logic        inst_ok_q, inst_ok_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic [1:0]  discard_cnt_q, discard_cnt_d;

  logic        cnt_zero, fs_waiting, take_data, fs_ready_go, load;
  logic [31:0] inst_out;
  logic [2:0]  cnt_sum;

  assign cnt_zero       = (discard_cnt_q == 2'd0);
  assign fs_waiting     = fs_valid_q && !ex_q && !inst_ok_q;
  assign take_data      = inst_sram_data_ok && cnt_zero && fs_waiting;
  assign fs_inst_unable = !fs_waiting && cnt_zero;
  assign fs_ready_go    = ex_q || inst_ok_q || take_data;
  assign fs_allowin     = !fs_valid_q || (fs_ready_go && ds_allowin);
  assign fs_to_ds_valid = fs_valid_q && fs_ready_go && !do_flush;
  assign fs_valid       = fs_valid_q;
  assign load           = pfs_to_fs_valid && fs_allowin && !do_flush;

  // The beat is forwarded straight through in the cycle it arrives; later it comes from inst_buf.
  assign inst_out     = (!fs_valid_q || ex_q) ? 32'd0
                      : (inst_ok_q ? inst_buf_q : inst_sram_rdata);
  assign fs_to_ds_bus = {ex_q, excode_q, badvaddr_q, tlb_refill_q, inst_out, pc_q};

  always_comb begin
    pc_d         = pc_q;
    ex_d         = ex_q;
    excode_d     = excode_q;
    badvaddr_d   = badvaddr_q;
    tlb_refill_d = tlb_refill_q;
    inst_ok_d    = inst_ok_q;
    inst_buf_d   = inst_buf_q;
    fs_valid_d   = fs_valid_q;

    if (load) begin
      tlb_refill_d = pfs_to_fs_bus[103];
      inst_ok_d    = pfs_to_fs_bus[102];
      inst_buf_d   = pfs_to_fs_bus[101:70];
      excode_d     = pfs_to_fs_bus[69:65];
      badvaddr_d   = pfs_to_fs_bus[64:33];
      ex_d         = pfs_to_fs_bus[32];
      pc_d         = pfs_to_fs_bus[31:0];
    end else if (take_data && !ds_allowin) begin
      inst_ok_d  = 1'b1;
      inst_buf_d = inst_sram_rdata;
    end

    if (do_flush) begin
      fs_valid_d = 1'b0;
    end else if (fs_allowin) begin
      fs_valid_d = pfs_to_fs_valid;
    end

    // Outstanding beats of killed requests: ours (unless it lands right now) plus PFS's.
    cnt_sum = {1'b0, discard_cnt_q};
    if (inst_sram_data_ok && !cnt_zero) begin
      cnt_sum = cnt_sum - 3'd1;
    end
    if (do_flush) begin
      cnt_sum = cnt_sum + {2'b00, fs_waiting && !inst_sram_data_ok} + {2'b00, pfs_inst_waiting};
    end
    discard_cnt_d = (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q    <= 1'b0;
      pc_q          <= 32'd0;
      ex_q          <= 1'b0;
      excode_q      <= 5'd0;
      badvaddr_q    <= 32'd0;
      tlb_refill_q  <= 1'b0;
      inst_ok_q     <= 1'b0;
      inst_buf_q    <= 32'd0;
      discard_cnt_q <= 2'd0;
    end else begin
      fs_valid_q    <= fs_valid_d;
      pc_q          <= pc_d;
      ex_q          <= ex_d;
      excode_q      <= excode_d;
      badvaddr_q    <= badvaddr_d;
      tlb_refill_q  <= tlb_refill_d;
      inst_ok_q     <= inst_ok_d;
      inst_buf_q    <= inst_buf_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage: a transaction-level model of the
// PFS, the in-order instruction bus and the FS slot predicts every cycle.
module tb_if_stage;
  logic         clk = 1'b0;
  logic         reset;
  logic         pfs_to_fs_valid;
  logic [103:0] pfs_to_fs_bus;
  logic         pfs_inst_waiting;
  logic         fs_allowin;
  logic         fs_valid;
  logic         fs_inst_unable;
  logic         inst_sram_data_ok;
  logic [31:0]  inst_sram_rdata;
  logic         ds_allowin;
  logic         fs_to_ds_valid;
  logic [102:0] fs_to_ds_bus;
  logic         do_flush;

  always #5 clk = ~clk;

  if_stage dut (
    .clk              (clk),
    .reset            (reset),
    .pfs_to_fs_valid  (pfs_to_fs_valid),
    .pfs_to_fs_bus    (pfs_to_fs_bus),
    .pfs_inst_waiting (pfs_inst_waiting),
    .fs_allowin       (fs_allowin),
    .fs_valid         (fs_valid),
    .fs_inst_unable   (fs_inst_unable),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata  (inst_sram_rdata),
    .ds_allowin       (ds_allowin),
    .fs_to_ds_valid   (fs_to_ds_valid),
    .fs_to_ds_bus     (fs_to_ds_bus),
    .do_flush         (do_flush)
  );

  typedef struct {
    logic [31:0] pc;
    logic        ex;
    logic [4:0]  excode;
    logic [31:0] badv;
    logic        tlb;
    logic        inst_ok;
    logic [31:0] inst_field;
    logic [31:0] exp_inst;
    bit          pending;
    int          req_id;
  } bnd_t;

  // owner: 0 = killed by a flush, 1 = bundle in FS, 2 = bundle held by PFS
  typedef struct {
    int          id;
    int          owner;
    logic [31:0] data;
  } req_t;

  typedef struct {
    bit   en;
    bit   deliver;
    logic valid_o;
    logic allowin;
    logic unable;
    logic fsv;
    bit   bus_en;
    logic [102:0] bus;
  } chk_t;

  req_t         bus_q[$];
  logic [102:0] exp_q[$];
  chk_t         chk_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int n_deliv = 0;
  int next_id = 0;

  bit   fs_has, pfs_has, fs_ready_r;
  bnd_t fs_b, pfs_b;

  task automatic check(input string name, input logic [102:0] act, input logic [102:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int stale_cnt();
    int n = 0;
    foreach (bus_q[i]) if (bus_q[i].owner == 0) n++;
    return n;
  endfunction

  function automatic logic [102:0] ds_bundle(input bnd_t b);
    return {b.ex, b.excode, b.badv, b.tlb, (b.ex ? 32'd0 : b.exp_inst), b.pc};
  endfunction

  function automatic logic [103:0] pfs_bundle(input bnd_t b);
    return {b.tlb, b.inst_ok, b.inst_field, b.excode, b.badv, b.ex, b.pc};
  endfunction

  task automatic new_bundle();
    bnd_t b;
    int   kind;
    kind         = int'($urandom_range(0, 9));
    b.pc         = 32'hBFC00000 + ($urandom_range(0, 255) << 2);
    b.excode     = 5'($urandom_range(0, 31));
    b.badv       = $urandom;
    b.tlb        = ($urandom_range(0, 1) == 1);
    b.inst_field = $urandom;
    b.pending    = 1'b0;
    b.req_id     = -1;
    if (kind >= 6 && bus_q.size() < 3) begin
      req_t r;
      r.id = next_id; r.owner = 2; r.data = $urandom;
      next_id++;
      bus_q.push_back(r);
      b.ex = 1'b0; b.inst_ok = 1'b0; b.exp_inst = r.data;
      b.pending = 1'b1; b.req_id = r.id;
    end else if (kind >= 4 && kind < 6) begin
      b.ex = 1'b1; b.inst_ok = ($urandom_range(0, 1) == 1); b.exp_inst = 32'd0;
    end else begin
      b.ex = 1'b0; b.inst_ok = 1'b1; b.exp_inst = b.inst_field;
    end
    pfs_b   = b;
    pfs_has = 1'b1;
  endtask

  task automatic step();
    bit   flush, ds, dok, pv, take, ready, exp_v, exp_allow, exp_unable;
    int   front;
    chk_t c;
    @(posedge clk);
    #1;
    flush = ($urandom_range(0, 15) == 0);
    ds    = ($urandom_range(0, 9) < 7);
    front = (bus_q.size() > 0) ? bus_q[0].owner : -1;
    dok   = (bus_q.size() > 0) && ($urandom_range(0, 1) == 1);
    if (flush && front != 1) dok = 1'b0;
    pv    = pfs_has && ($urandom_range(0, 3) != 0) && !(dok && front == 2);

    reset             = 1'b0;
    pfs_to_fs_valid   = pv;
    pfs_to_fs_bus     = pfs_has ? pfs_bundle(pfs_b) : {$urandom, $urandom, $urandom, 8'($urandom)};
    pfs_inst_waiting  = pfs_has && pfs_b.pending;
    inst_sram_data_ok = dok;
    inst_sram_rdata   = dok ? bus_q[0].data : $urandom;
    ds_allowin        = ds;
    do_flush          = flush;

    take       = dok && (front == 1);
    ready      = fs_has && (fs_ready_r || take);
    exp_v      = ready && !flush;
    exp_allow  = !fs_has || (ready && ds);
    exp_unable = !(fs_has && !fs_ready_r) && (stale_cnt() == 0);
    c.en = 1'b1; c.deliver = exp_v && ds; c.valid_o = exp_v; c.allowin = exp_allow;
    c.unable = exp_unable; c.fsv = fs_has; c.bus_en = 1'b0; c.bus = '0;
    chk_q.push_back(c);

    if (dok) begin
      req_t e;
      e = bus_q.pop_front();
      if (e.owner == 1) begin
        fs_ready_r = 1'b1;
      end else if (e.owner == 2) begin
        pfs_b.pending    = 1'b0;
        pfs_b.inst_ok    = 1'b1;
        pfs_b.inst_field = e.data;
      end
    end
    if (flush) begin
      fs_has  = 1'b0;
      pfs_has = 1'b0;
      foreach (bus_q[i]) bus_q[i].owner = 0;
      exp_q.delete();
    end else if (pv && exp_allow) begin
      fs_b       = pfs_b;
      fs_has     = 1'b1;
      fs_ready_r = !fs_b.pending;
      if (fs_b.pending) foreach (bus_q[i]) if (bus_q[i].id == fs_b.req_id) bus_q[i].owner = 1;
      exp_q.push_back(ds_bundle(fs_b));
      pfs_has = 1'b0;
    end else if (exp_v && ds) begin
      fs_has = 1'b0;
    end
    if (!pfs_has && $urandom_range(0, 2) != 0) new_bundle();
  endtask

  task automatic mid_reset();
    chk_t c;
    @(posedge clk);
    #1;
    reset = 1'b1; pfs_to_fs_valid = 1'b0; inst_sram_data_ok = 1'b0;
    do_flush = 1'b0; inst_sram_rdata = 32'd0; pfs_inst_waiting = 1'b0;
    c.en = 1'b0; c.deliver = 1'b0; c.valid_o = 1'b0; c.allowin = 1'b0;
    c.unable = 1'b0; c.fsv = 1'b0; c.bus_en = 1'b0; c.bus = '0;
    chk_q.push_back(c);
    fs_has = 1'b0; pfs_has = 1'b0; fs_ready_r = 1'b0;
    bus_q.delete();
    exp_q.delete();
  endtask

  // Monitor: compares each cycle's outputs and pops the scoreboard on every DS handshake.
  chk_t         mc;
  logic [102:0] mexp;
  always @(negedge clk) begin
    if (chk_q.size() > 0) begin
      mc = chk_q.pop_front();
      if (mc.en) begin
        check("fs_to_ds_valid", 103'(fs_to_ds_valid), 103'(mc.valid_o));
        check("fs_allowin", 103'(fs_allowin), 103'(mc.allowin));
        check("fs_inst_unable", 103'(fs_inst_unable), 103'(mc.unable));
        check("fs_valid", 103'(fs_valid), 103'(mc.fsv));
        if (mc.bus_en) check("fs_to_ds_bus", fs_to_ds_bus, mc.bus);
        if (mc.deliver) begin
          if (exp_q.size() == 0) begin
            check("scoreboard_empty", 103'(1), 103'(0));
          end else begin
            mexp = exp_q.pop_front();
            check("bundle", fs_to_ds_bus, mexp);
            n_deliv++;
            $display("deliver pc=%h inst=%h ex=%b excode=%h", fs_to_ds_bus[31:0],
                     fs_to_ds_bus[63:32], fs_to_ds_bus[102], fs_to_ds_bus[101:97]);
          end
        end
      end
    end
  end

  initial begin
    chk_t c;
    reset = 1'b1; pfs_to_fs_valid = 1'b0; pfs_to_fs_bus = '0; pfs_inst_waiting = 1'b0;
    inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'd0; ds_allowin = 1'b1; do_flush = 1'b0;
    fs_has = 1'b0; pfs_has = 1'b0; fs_ready_r = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    c.en = 1'b1; c.deliver = 1'b0; c.valid_o = 1'b0; c.allowin = 1'b1; c.unable = 1'b1;
    c.fsv = 1'b0; c.bus_en = 1'b1; c.bus = '0;
    chk_q.push_back(c);

    for (int i = 0; i < 2000; i++) step();
    mid_reset();
    for (int i = 0; i < 2000; i++) step();

    @(negedge clk);
    #1;
    check("deliveries", 103'(n_deliv >= 100), 103'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
